screen_writer: RTL and testbench
================================

Name: screen_writer

Overview:
- Write-side engine for the character screen memory that the VGA display driver reads through screenAddr/character.
- Accepts draw commands from game logic over a valid/ready handshake. Commands are write cell, fill row, clear screen, and scroll down one row.
- Converts each command into a sequence of single-port RAM accesses: 11-bit address, 3-bit character code, synchronous read with 1-cycle latency.
- Sits between the game FSM and the screen RAM write/read port.

Parameters:
- COLS, 40, characters per row.
- ROWS, 30, rows per screen. COLS*ROWS must not exceed 2048.
- BLANK_CHAR, 3'd0, character code meaning an empty cell.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmdValid  input  1  command present
- cmdReady  output  1  block can accept a command
- cmdOp  input  2  0=WRITE, 1=FILL_ROW, 2=CLEAR, 3=SCROLL
- cmdRow  input  5  target row (WRITE, FILL_ROW)
- cmdCol  input  6  target column (WRITE)
- cmdChar  input  3  character to write/fill; SCROLL: row-0 fill code
- memWe  output  1  RAM write enable
- memAddr  output  11  RAM address (read or write)
- memWrData  output  3  RAM write data
- memRdData  input  3  RAM read data, valid 1 cycle after memAddr presented with memWe=0
- busy  output  1  command in progress
- done  output  1  one-cycle pulse on the last cycle of every accepted command
- vsync  input  1  VGA vsync, active low; used only with the optional feature

Behaviour:
- Reset (async, rst_n=0): state IDLE; memWe=0, memAddr=0, memWrData=0, busy=0, done=0, cmdReady=0 while rst_n low.
  - Reset mid-command aborts immediately. RAM keeps any partial contents.
- Handshake:
  - cmdReady=1 only in IDLE with rst_n high.
  - A command is accepted on a rising edge with cmdValid&&cmdReady; cmdOp/Row/Col/Char are latched there.
  - busy=1 from the next cycle until done.
  - cmdReady returns to 1 the cycle after done. There is no back-to-back acceptance.
- Address: addr = row*COLS + col, computed in 11 bits. All outputs are registered.
- States: IDLE, WRITE, FILL, SCR_RD, SCR_WR, SCR_TOP, and WAIT_VS (optional feature only).
- WRITE: cycle T+1 after acceptance drives memWe=1, addr(cmdRow,cmdCol), memWrData=cmdChar, done=1. Latency 1.
- FILL_ROW: COLS consecutive write cycles, columns 0..COLS-1 ascending. done coincides with the column COLS-1 write.
- CLEAR: COLS*ROWS consecutive writes, address 0 up to COLS*ROWS-1, data=cmdChar. done on the last write.
- SCROLL:
  - For dest d from COLS*ROWS-1 down to COLS: SCR_RD drives memAddr=d-COLS, memWe=0. SCR_WR drives memAddr=d, memWe=1, memWrData=memRdData. That is 2 cycles per cell.
  - Then SCR_TOP writes cmdChar to addresses 0..COLS-1 ascending. done on address COLS-1.
  - Total 2*(ROWS-1)*COLS + COLS cycles.
- Out of range (cmdRow>=ROWS, or cmdCol>=COLS for WRITE): no memWe for the whole command. done still pulses 1 cycle after acceptance.
- cmdChar==BLANK_CHAR has no special handling.
- memWe is never asserted outside WRITE, FILL, SCR_WR and SCR_TOP.
- cmdValid dropping while busy has no effect.

Optional Feature:
- Macro SCREEN_WRITER_VSYNC_SYNC_EN.
- Defined:
  - CLEAR and SCROLL enter WAIT_VS after acceptance, with busy=1 and memWe=0.
  - vsync passes through a 2-flop synchronizer. Memory activity starts the cycle after a falling edge (1 to 0) of the synchronized vsync. This avoids visible tearing.
  - WRITE and FILL_ROW are unaffected.
- Undefined: vsync is ignored and WAIT_VS is not built.

Test Plan:
- Reset with rst_n=0 mid-CLEAR at address 500 -> next cycle memWe=0, busy=0, done=0. After release, cmdReady=1 and address 500 is never written.
- WRITE row=2, col=5, char=3 -> exactly one cycle with memWe=1, memAddr=85, memWrData=3; done in the same cycle; cmdReady=1 on the following cycle.
- FILL_ROW row=29, char=7 -> 40 consecutive writes to addresses 1160..1199 with data 7; done on address 1199.
- CLEAR char=0 with a RAM model -> 1200 writes covering 0..1199, all cells read back 0; done after 1200 write cycles.
- SCROLL char=0 after seeding cell (r,c) with (r+c)%8 -> after 2360 cycles, row r for r>=1 holds the old row r-1 and row 0 is all 0.
- WRITE row=30, col=0 and WRITE row=0, col=40 -> no memWe; done pulses 1 cycle after acceptance. With SCREEN_WRITER_VSYNC_SYNC_EN, CLEAR stalls with memWe=0 until vsync falls, then the first write is 3 cycles after the raw edge.

Source files
------------

// File: rtl/screen_writer_if.sv
// Command channel from game logic to the screen writer: valid/ready handshake
// carrying the opcode, target cell and character code.
interface screen_writer_if;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [4:0] cmdRow;
    logic [5:0] cmdCol;
    logic [2:0] cmdChar;

    modport master (output cmdValid, cmdOp, cmdRow, cmdCol, cmdChar, input cmdReady);
    modport slave  (input cmdValid, cmdOp, cmdRow, cmdCol, cmdChar, output cmdReady);
endinterface

// File: rtl/screen_writer.sv
// screen_writer: turns draw commands (write/fill/clear/scroll) into single-port screen RAM accesses.
// Optional macro SCREEN_WRITER_VSYNC_SYNC_EN holds CLEAR/SCROLL until the synchronized vsync falls.
module screen_writer #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [2:0] BLANK_CHAR = 3'd0
) (
    input  logic           clk,
    input  logic           rst_n,
    screen_writer_if.slave cmd,
    output logic           memWe,
    output logic [10:0]    memAddr,
    output logic [2:0]     memWrData,
    input  logic [2:0]     memRdData,
    output logic           busy,
    output logic           done,
    input  logic           vsync
);
    localparam int          TOTAL  = COLS * ROWS;
    localparam logic [10:0] COLS_A = 11'(COLS);
    localparam logic [10:0] LAST_A = 11'(TOTAL - 1);

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_FILL   = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, WRITE, FILL, SCR_RD, SCR_WR, SCR_TOP
`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
        , WAIT_VS
`endif
    } state_t;

    state_t      state, state_n;
    logic [10:0] addr_q, addr_n, last_q, last_n;
    logic [2:0]  wdata_q, wdata_n, char_q, char_n, bulk_char;
    logic [1:0]  op_q, op_n, bulk_op;
    logic        we_n, done_n, ready_q, bulk_go;
    logic        accept, row_ok, col_ok;
    logic [10:0] row_base;

    // Blank cells need no special treatment; the code is kept for callers.
    logic [2:0] unused_blank;
    assign unused_blank = BLANK_CHAR;

`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
    logic vs_s1, vs_s2, vs_s3, vs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_s3 <= 1'b1;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign vs_fall = vs_s3 & ~vs_s2;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    assign accept   = (state == IDLE) && cmd.cmdValid && ready_q;
    assign row_base = 11'(cmd.cmdRow) * COLS_A;
    assign row_ok   = int'(cmd.cmdRow) < ROWS;
    assign col_ok   = int'(cmd.cmdCol) < COLS;

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        last_n    = last_q;
        wdata_n   = wdata_q;
        char_n    = char_q;
        op_n      = op_q;
        we_n      = 1'b0;
        done_n    = 1'b0;
        bulk_go   = 1'b0;
        bulk_op   = op_q;
        bulk_char = char_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    char_n  = cmd.cmdChar;
                    op_n    = cmd.cmdOp;
                    wdata_n = cmd.cmdChar;
                    case (cmd.cmdOp)
                        OP_WRITE: begin
                            state_n = WRITE;
                            addr_n  = row_base + 11'(cmd.cmdCol);
                            we_n    = row_ok && col_ok;
                            done_n  = 1'b1;
                        end
                        OP_FILL: begin
                            if (row_ok) begin
                                state_n = FILL;
                                addr_n  = row_base;
                                last_n  = row_base + COLS_A - 11'd1;
                                we_n    = 1'b1;
                                done_n  = (COLS == 1);
                            end else begin
                                // Out-of-range rows finish in one silent cycle.
                                state_n = WRITE;
                                done_n  = 1'b1;
                            end
                        end
                        default: begin
`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
                            state_n = WAIT_VS;
`else
                            bulk_go   = 1'b1;
                            bulk_op   = cmd.cmdOp;
                            bulk_char = cmd.cmdChar;
`endif
                        end
                    endcase
                end
            end
            WRITE: state_n = IDLE;
            FILL, SCR_TOP: begin
                if (addr_q == last_q) begin
                    state_n = IDLE;
                end else begin
                    addr_n = addr_q + 11'd1;
                    we_n   = 1'b1;
                    done_n = (addr_q + 11'd1 == last_q);
                end
            end
            SCR_RD: begin
                state_n = SCR_WR;
                addr_n  = addr_q + COLS_A;
                we_n    = 1'b1;
            end
            SCR_WR: begin
                if (addr_q == COLS_A) begin
                    state_n = SCR_TOP;
                    addr_n  = 11'd0;
                    last_n  = COLS_A - 11'd1;
                    we_n    = 1'b1;
                    wdata_n = char_q;
                    done_n  = (COLS == 1);
                end else begin
                    // Walk destinations downward so sources are never overwritten first.
                    state_n = SCR_RD;
                    addr_n  = addr_q - COLS_A - 11'd1;
                end
            end
`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
            WAIT_VS: bulk_go = vs_fall;
`endif
            default: state_n = IDLE;
        endcase

        if (bulk_go) begin
            if (bulk_op == OP_CLEAR) begin
                state_n = FILL;
                addr_n  = 11'd0;
                last_n  = LAST_A;
                we_n    = 1'b1;
                wdata_n = bulk_char;
                done_n  = (TOTAL == 1);
            end else if (ROWS > 1) begin
                state_n = SCR_RD;
                addr_n  = LAST_A - COLS_A;
            end else begin
                state_n = SCR_TOP;
                addr_n  = 11'd0;
                last_n  = COLS_A - 11'd1;
                we_n    = 1'b1;
                wdata_n = bulk_char;
                done_n  = (COLS == 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            wdata_q <= '0;
            char_q  <= '0;
            op_q    <= '0;
            memWe   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            last_q  <= last_n;
            wdata_q <= wdata_n;
            char_q  <= char_n;
            op_q    <= op_n;
            memWe   <= we_n;
            done    <= done_n;
            busy    <= (state_n != IDLE);
            ready_q <= (state_n == IDLE);
        end
    end

    // Scroll copies take the RAM's registered read data straight through.
    assign memWrData    = (state == SCR_WR) ? memRdData : wdata_q;
    assign memAddr      = addr_q;
    assign cmd.cmdReady = ready_q;
endmodule

// File: tb/tb_screen_writer.sv
// Scoreboard bench for screen_writer: expected RAM accesses are queued by the stimulus
// and popped by a monitor on every write or done cycle.
module tb_screen_writer;
    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int TOTAL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic        memWe, busy, done;
    logic [10:0] memAddr;
    logic [2:0]  memWrData, memRdData;
    logic [2:0]  ram [0:2047];

    screen_writer_if cmd_bus();

    screen_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(3'd0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd_bus),
        .memWe(memWe),
        .memAddr(memAddr),
        .memWrData(memWrData),
        .memRdData(memRdData),
        .busy(busy),
        .done(done),
        .vsync(vsync)
    );

    always #5 clk = ~clk;

`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
    always begin
        #400 vsync = 1'b0;
        #40  vsync = 1'b1;
    end
`endif

    always @(posedge clk) begin
        if (memWe) ram[memAddr] <= memWrData;
        memRdData <= ram[memAddr];
    end

    typedef struct packed {
        logic        we;
        logic        dn;
        logic [10:0] addr;
        logic [2:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void push(input logic we, input logic dn, input int addr, input int data);
        exp_t e;
        e.we   = we;
        e.dn   = dn;
        e.addr = we ? 11'(addr) : 11'd0;
        e.data = we ? 3'(data) : 3'd0;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n && (memWe || done)) begin
            exp_t e;
            logic [15:0] seen;
            seen = {memWe, done, memWe ? memAddr : 11'd0, memWe ? memWrData : 3'd0};
            if (exp_q.size() == 0) begin
                chk("unexpected_access", 32'(seen), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("access", 32'(seen), 32'(e));
            end
        end
    end

    task automatic send(input int op, input int row, input int col, input int ch);
        int n;
        n = 0;
        @(negedge clk);
        cmd_bus.cmdValid = 1'b1;
        cmd_bus.cmdOp    = 2'(op);
        cmd_bus.cmdRow   = 5'(row);
        cmd_bus.cmdCol   = 6'(col);
        cmd_bus.cmdChar  = 3'(ch);
        while (!cmd_bus.cmdReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_bus.cmdReady) chk("accept_timeout", 32'(n), 0);
        @(posedge clk);
        #1 cmd_bus.cmdValid = 1'b0;
    endtask

    task automatic run(input int op, input int row, input int col, input int ch,
                       input int lat, input string name);
        int n;
        send(op, row, col, ch);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 5000);
`ifdef SCREEN_WRITER_VSYNC_SYNC_EN
        if (op >= 2) chk({name, "_latency_window"}, 32'(n >= lat && n <= lat + 50), 1);
        else chk({name, "_latency"}, 32'(n), 32'(lat));
`else
        chk({name, "_latency"}, 32'(n), 32'(lat));
`endif
        chk({name, "_busy_at_done"}, 32'(busy), 1);
        @(negedge clk);
        chk({name, "_ready_after"}, {busy, cmd_bus.cmdReady}, 32'b01);
    endtask

    initial begin
        int bad;
        int n;
        logic [2:0] old [0:2047];

        cmd_bus.cmdValid = 1'b0;
        cmd_bus.cmdOp    = 2'd0;
        cmd_bus.cmdRow   = 5'd0;
        cmd_bus.cmdCol   = 6'd0;
        cmd_bus.cmdChar  = 3'd0;
        for (int i = 0; i < 2048; i++) ram[i] = 3'd0;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {memWe, memAddr, memWrData, busy, done, cmd_bus.cmdReady}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_bus.cmdReady), 1);

        // Single cell: row 2, col 5 -> 2*40+5 = 85.
        push(1, 1, 85, 3);
        run(0, 2, 5, 3, 1, "write");

        // Bottom row fill: 29*40 = 1160 .. 1199.
        for (int a = 1160; a < 1200; a++) push(1, a == 1199, a, 7);
        run(1, 29, 0, 7, COLS, "fill");

        push(0, 1, 0, 0);
        run(0, 30, 0, 1, 1, "oob_row");
        push(0, 1, 0, 0);
        run(0, 0, 40, 1, 1, "oob_col");
        push(0, 1, 0, 0);
        run(1, 31, 0, 2, 1, "oob_fill");

        for (int i = 0; i < TOTAL; i++) ram[i] = 3'd6;
        for (int i = 0; i < TOTAL; i++) push(1, i == TOTAL - 1, i, 0);
        run(2, 0, 0, 0, TOTAL, "clear");
        bad = 0;
        for (int i = 0; i < TOTAL; i++) if (ram[i] !== 3'd0) bad++;
        chk("clear_readback", 32'(bad), 0);

        for (int i = 0; i < TOTAL; i++) begin
            ram[i] = 3'((i / COLS + i % COLS) % 8);
            old[i] = ram[i];
        end
        for (int d = TOTAL - 1; d >= COLS; d--) push(1, 0, d, old[d - COLS]);
        for (int a = 0; a < COLS; a++) push(1, a == COLS - 1, a, 0);
        run(3, 0, 0, 0, 2 * (ROWS - 1) * COLS + COLS, "scroll");
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (ram[r * COLS + c] !== ((r == 0) ? 3'd0 : 3'((r - 1 + c) % 8))) bad++;
        chk("scroll_readback", 32'(bad), 0);

        // Abort a clear just as it presents address 500.
        for (int i = 0; i < TOTAL; i++) ram[i] = 3'd5;
        for (int i = 0; i < TOTAL; i++) push(1, i == TOTAL - 1, i, 0);
        send(2, 0, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(memWe && memAddr == 11'd500) && n < 5000);
        chk("reach_addr_500", 32'(n < 5000), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {memWe, busy, done, cmd_bus.cmdReady}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_abort", 32'(cmd_bus.cmdReady), 1);
        chk("addr_500_untouched", 32'(ram[500]), 5);
        chk("addr_499_cleared", 32'(ram[499]), 0);

        push(1, 1, 0, 4);
        run(0, 0, 0, 4, 1, "write_after_abort");
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
